multdiv_issue: RTL and testbench
================================

MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum number of WAIT-state cycles before an operation is aborted.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_mult  input  1  execute stage holds a valid MULT.
REQ-005 SHALL have port start_div  input  1  execute stage holds a valid DIV.
REQ-006 SHALL have port opA  input  32  first source operand from the execute stage.
REQ-007 SHALL have port opB  input  32  second source operand from the execute stage.
REQ-008 SHALL have port rd  input  5  destination register of the operation.
REQ-009 SHALL have port md_result  input  32  result from the multiplier/divider.
REQ-010 SHALL have port md_exception  input  1  exception flag from the multiplier/divider.
REQ-011 SHALL have port md_resultRDY  input  1  result-ready strobe from the multiplier/divider.
REQ-012 SHALL have port ctrl_MULT  output  1  one-cycle multiply start pulse.
REQ-013 SHALL have port ctrl_DIV  output  1  one-cycle divide start pulse.
REQ-014 SHALL have port md_operandA  output  32  latched operand A.
REQ-015 SHALL have port md_operandB  output  32  latched operand B.
REQ-016 SHALL have port stall  output  1  pipeline freeze request.
REQ-017 SHALL have port wb_valid  output  1  one-cycle writeback strobe.
REQ-018 SHALL have port wb_data  output  32  writeback data.
REQ-019 SHALL have port wb_rd  output  5  writeback destination register.
REQ-020 SHALL have port wb_exception  output  1  writeback exception flag (hardware fault or timeout).

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE, plus a cycle counter sized to hold TIMEOUT.
REQ-022 In IDLE with start_mult or start_div high, the block SHALL latch opA, opB, rd and the op type, then go to ISSUE.
REQ-023 When start_mult and start_div are both high, the block SHALL treat the operation as a MULT and ignore the DIV.
REQ-024 stall SHALL equal (state is ISSUE or WAIT) OR (state is IDLE AND (start_mult OR start_div)), as a combinational function of state and inputs.
REQ-025 In ISSUE, exactly one of ctrl_MULT or ctrl_DIV SHALL be high for exactly one cycle; the counter SHALL clear; next state SHALL be WAIT.
REQ-026 md_operandA and md_operandB SHALL hold their latched values, unchanged, from ISSUE through DONE.
REQ-027 md_resultRDY SHALL be ignored in IDLE, ISSUE and DONE; a stale strobe in ISSUE SHALL NOT complete the operation.
REQ-028 In WAIT, the counter SHALL increment each cycle.
REQ-029 In WAIT with md_resultRDY high, the block SHALL register wb_data=md_result, wb_exception=md_exception and wb_rd=latched rd, then go to DONE.
REQ-030 In WAIT, if the counter reaches TIMEOUT-1 with md_resultRDY low, the block SHALL register wb_data=0, wb_exception=1 and wb_rd=latched rd, then go to DONE.
REQ-031 When md_resultRDY arrives in the same cycle as the timeout, the block SHALL accept the result and SHALL NOT flag a timeout.
REQ-032 In DONE, the block SHALL assert wb_valid for one cycle, deassert stall and return to IDLE.
REQ-033 start_mult and start_div SHALL be ignored in DONE, because the completing instruction is still present in execute.
REQ-034 wb_data, wb_rd and wb_exception SHALL hold their values until the next DONE.
REQ-035 wb_valid SHALL pulse even when rd=0; write suppression for rd=0 is downstream's responsibility.
REQ-036 Minimum occupancy SHALL be 1 cycle (IDLE accept) + 1 (ISSUE) + N (WAIT) + 1 (DONE).
REQ-037 Back-to-back operations SHALL be accepted no earlier than the IDLE cycle following DONE.

Reset
REQ-038 While reset is high, the state SHALL be IDLE, the counter SHALL be 0, and all registered outputs (ctrl_MULT, ctrl_DIV, md_operandA, md_operandB, wb_valid, wb_data, wb_rd, wb_exception) SHALL be 0; stall SHALL be 0 unless a start input is high.
REQ-039 Reset asserted in ISSUE, WAIT or DONE SHALL abort the operation immediately, with no ctrl pulse and no wb_valid emitted.
REQ-040 An md_resultRDY arriving after such a reset SHALL be ignored.

Verification
REQ-041 Bench SHALL cover: start_mult, opA=6, opB=7, rd=5, RDY after 33 WAIT cycles with md_result=42 -> single ctrl_MULT pulse, stall high from the accept cycle through WAIT, wb_valid one cycle with wb_data=42, wb_rd=5, wb_exception=0.
REQ-042 Bench SHALL cover: start_div, opA=9, opB=0, model returns md_exception=1 -> single ctrl_DIV pulse, wb_exception=1, wb_rd latched.
REQ-043 Bench SHALL cover: start_mult with md_resultRDY never asserted, TIMEOUT=40 -> DONE after 40 WAIT cycles with wb_data=0, wb_exception=1, and stall released.
REQ-044 Bench SHALL cover: start_mult=start_div=1 in the same cycle -> only ctrl_MULT pulses; also md_resultRDY forced high during ISSUE -> no early completion.
REQ-045 Bench SHALL cover: reset pulsed at WAIT cycle 10, then a late RDY -> no wb_valid, state IDLE, all outputs 0.
REQ-046 Bench SHALL cover: back-to-back MULT then DIV with start held through DONE -> exactly two ISSUE pulses and two wb_valid strobes, and no duplicate op from the held start.

Source files
------------

// File: rtl/multdiv_issue.sv
// Issues one MULT/DIV to the external unit, waits for its result or a timeout, then pulses writeback.
// Latency: accept + ISSUE + N WAIT + DONE; stall holds the pipeline from the accept cycle until DONE.
module multdiv_issue #(
   parameter int TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic [4:0]  rd,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_exception
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [4:0]    rd_q;
   logic          accept, finish_ok, finish_to;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      accept    = 1'b0;
      finish_ok = 1'b0;
      finish_to = 1'b0;
      case (state)
         IDLE: begin
            if (start_mult || start_div) begin
               stall     = 1'b1;
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            stall     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            // A result landing on the timeout cycle wins over the timeout.
            if (md_resultRDY) begin
               finish_ok = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               finish_to = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_q         <= '0;
         ctrl_MULT    <= 1'b0;
         ctrl_DIV     <= 1'b0;
         md_operandA  <= '0;
         md_operandB  <= '0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_rd        <= '0;
         wb_exception <= 1'b0;
      end else begin
         state     <= state_nxt;
         // MULT has priority when both starts are presented together.
         ctrl_MULT <= accept & start_mult;
         ctrl_DIV  <= accept & ~start_mult;
         wb_valid  <= finish_ok | finish_to;
         if (accept) begin
            md_operandA <= opA;
            md_operandB <= opB;
            rd_q        <= rd;
         end
         if (state == ISSUE) begin
            cnt <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (finish_ok) begin
            wb_data      <= md_result;
            wb_exception <= md_exception;
            wb_rd        <= rd_q;
         end else if (finish_to) begin
            wb_data      <= '0;
            wb_exception <= 1'b1;
            wb_rd        <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed and randomized checks of multdiv_issue against a cycle-indexed reference of each operation.
module tb_multdiv_issue;

   localparam int TIMEOUT = 40;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] opA, opB, md_result;
   logic [4:0]  rd;
   logic        md_exception, md_resultRDY;
   logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception;
   logic [31:0] md_operandA, md_operandB, wb_data;
   logic [4:0]  wb_rd;

   int compared   = 0;
   int mismatched = 0;
   int pulses     = 0;
   int wb_count   = 0;

   logic [31:0] prev_data;
   logic [4:0]  prev_rd;
   logic        prev_exc;

   multdiv_issue #(.TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .start_mult(start_mult), .start_div(start_div),
      .opA(opA), .opB(opB), .rd(rd),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_exception(wb_exception)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctrlM"}, ctrl_MULT, 0);
      chk({tag, "_ctrlD"}, ctrl_DIV, 0);
      chk({tag, "_wbv"}, wb_valid, 0);
      chk({tag, "_stall"}, stall, 0);
   endtask

   // One complete operation. Cycle 0 is the IDLE accept, 1 is ISSUE, WAIT follows,
   // DONE is last. lat = WAIT cycles with RDY low before RDY rises (>= TIMEOUT: never).
   task automatic run_op(input string tag, input bit sm, input bit sd,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                         input int lat, input logic [31:0] res, input bit exc,
                         input bit hold, input bit stale_rdy);
      bit          ok    = (lat < TIMEOUT);
      int          w     = ok ? lat + 1 : TIMEOUT;
      int          done  = w + 2;
      logic [31:0] e_dat = ok ? res : 32'd0;
      bit          e_exc = ok ? exc : 1'b1;
      for (int c = 0; c <= done; c++) begin
         @(negedge clock);
         start_mult   = (c == 0 || hold) ? sm : 1'b0;
         start_div    = (c == 0 || hold) ? sd : 1'b0;
         opA          = (c == 0) ? a : $urandom;
         opB          = (c == 0) ? b : $urandom;
         rd           = (c == 0) ? r : 5'($urandom);
         md_resultRDY = (c == 1 && stale_rdy) || (ok && c == lat + 2);
         md_result    = (c == lat + 2) ? res : $urandom;
         md_exception = (c == lat + 2) ? exc : 1'($urandom);
         #1;
         pulses   += int'(ctrl_MULT) + int'(ctrl_DIV);
         wb_count += int'(wb_valid);
         chk({tag, "_stall"}, stall, c < done);
         chk({tag, "_ctrlM"}, ctrl_MULT, c == 1 && sm);
         chk({tag, "_ctrlD"}, ctrl_DIV, c == 1 && !sm);
         chk({tag, "_wbv"}, wb_valid, c == done);
         if (c >= 1) begin
            chk({tag, "_opA"}, md_operandA, a);
            chk({tag, "_opB"}, md_operandB, b);
         end
         if (c == done) begin
            chk({tag, "_wbdat"}, wb_data, e_dat);
            chk({tag, "_wbrd"}, wb_rd, r);
            chk({tag, "_wbexc"}, wb_exception, e_exc);
         end else begin
            chk({tag, "_hold_dat"}, wb_data, prev_data);
            chk({tag, "_hold_rd"}, wb_rd, prev_rd);
            chk({tag, "_hold_exc"}, wb_exception, prev_exc);
         end
      end
      prev_data = e_dat;
      prev_rd   = r;
      prev_exc  = e_exc;
      start_mult   = 1'b0;
      start_div    = 1'b0;
      md_resultRDY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, w0;
      reset = 1'b1; start_mult = 0; start_div = 0; opA = 0; opB = 0; rd = 0;
      md_result = 0; md_exception = 0; md_resultRDY = 0;
      prev_data = 0; prev_rd = 0; prev_exc = 0;

      // Reset state, and stall as a pure function of start while in reset.
      @(negedge clock); #1;
      chk_quiet("rst");
      chk("rst_opA", md_operandA, 0);
      chk("rst_wbdat", wb_data, 0);
      chk("rst_wbrd", wb_rd, 0);
      chk("rst_wbexc", wb_exception, 0);
      start_mult = 1'b1; #1;
      chk("rst_stall_start", stall, 1);
      start_mult = 1'b0;
      @(negedge clock); reset = 1'b0;

      // Directed operations.
      run_op("mul42", 1, 0, 32'd6, 32'd7, 5'd5, 33, 32'd42, 0, 0, 0);
      run_op("div0", 0, 1, 32'd9, 32'd0, 5'd17, 4, 32'hdead, 1, 0, 0);
      run_op("tmo", 1, 0, 32'h1234, 32'h5678, 5'd3, 1000, 32'hffff, 0, 0, 0);
      run_op("both_stale", 1, 1, 32'd11, 32'd13, 5'd9, 3, 32'd143, 0, 0, 1);
      run_op("coincide", 0, 1, 32'd100, 32'd7, 5'd1, TIMEOUT - 1, 32'd14, 0, 0, 0);
      run_op("minlat_rd0", 1, 0, 32'd2, 32'd3, 5'd0, 0, 32'd6, 0, 0, 0);

      // Back-to-back with the first start held through DONE.
      p0 = pulses; w0 = wb_count;
      run_op("b2b_mul", 1, 0, 32'd5, 32'd5, 5'd20, 2, 32'd25, 0, 1, 0);
      run_op("b2b_div", 0, 1, 32'd50, 32'd5, 5'd21, 6, 32'd10, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         pulses   += int'(ctrl_MULT) + int'(ctrl_DIV);
         wb_count += int'(wb_valid);
         chk_quiet("b2b_idle");
      end
      chk("b2b_ctrl_pulses", pulses - p0, 2);
      chk("b2b_wb_strobes", wb_count - w0, 2);

      // Reset in WAIT cycle 10, then a late RDY.
      @(negedge clock);
      start_mult = 1'b1; opA = 32'd77; opB = 32'd88; rd = 5'd12; #1;
      chk("rstw_accept_stall", stall, 1);
      @(negedge clock); start_mult = 1'b0; #1;
      chk("rstw_issue", ctrl_MULT, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock); #1;
         chk("rstw_wait_stall", stall, 1);
      end
      @(negedge clock); reset = 1'b1; #1;
      chk_quiet("rstw_in");
      chk("rstw_opA", md_operandA, 0);
      chk("rstw_opB", md_operandB, 0);
      chk("rstw_wbdat", wb_data, 0);
      chk("rstw_wbexc", wb_exception, 0);
      @(negedge clock); reset = 1'b0;
      md_resultRDY = 1'b1; md_result = 32'h5555; md_exception = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         chk_quiet("rstw_late");
         chk("rstw_late_wbdat", wb_data, 0);
         chk("rstw_late_wbrd", wb_rd, 0);
      end
      md_resultRDY = 1'b0;
      prev_data = 0; prev_rd = 0; prev_exc = 0;
      run_op("post_rst", 0, 1, 32'd8, 32'd2, 5'd30, 1, 32'd4, 0, 0, 0);

      // Randomized operations.
      for (int n = 0; n < 12; n++) begin
         bit sm, sd;
         int sel = $urandom_range(0, 2);
         sm = (sel != 1);
         sd = (sel != 0);
         run_op("rand", sm, sd, $urandom, $urandom, 5'($urandom),
                $urandom_range(0, TIMEOUT + 5), $urandom, 1'($urandom),
                1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
